// File: rtl/aircon_cycle_controller_pkg.sv
// Shared types and default constants for the air-conditioner cycle controller.
package aircon_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    LOCKOUT = 2'd1,
    IDLE    = 2'd2,
    COOL    = 2'd3
  } state_e;

  localparam int MIN_TEMP_DEFAULT      = 17;
  localparam int HYST_DEFAULT          = 1;
  localparam int MIN_OFF_TICKS_DEFAULT = 3;
  localparam int MIN_ON_TICKS_DEFAULT  = 2;

  // Unsigned maximum of two 5-bit values.
  function automatic logic [4:0] max5(input logic [4:0] a, input logic [4:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aircon_cycle_controller_if.sv
// Bundle of user settings, sensor sample, strobes and driver outputs of the controller.
interface aircon_cycle_controller_if;

  logic       i;
  logic       tick;
  logic [4:0] set_temp;
  logic [4:0] room_temp;
  logic [2:0] fan_set;
  logic [4:0] timer_set;
  logic       timer_load;
  logic       compressor;
  logic [2:0] fan;
  logic [4:0] timer_left;
  logic [1:0] state;
  logic       expired;

  modport master (
    output i, tick, set_temp, room_temp, fan_set, timer_set, timer_load,
    input  compressor, fan, timer_left, state, expired
  );

  modport slave (
    input  i, tick, set_temp, room_temp, fan_set, timer_set, timer_load,
    output compressor, fan, timer_left, state, expired
  );

endinterface

// File: rtl/aircon_cycle_controller_tick_down_counter.sv
// Loadable 5-bit down-counter advanced by the minute tick; used for the
// compressor guard and for the sleep timer.
module tick_down_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [4:0] value,
  input  logic       tick,
  output logic [4:0] count,
  output logic       zero
);

  logic [4:0] count_q;
  logic [4:0] count_d;

  // Clear beats load, load beats a tick, and a tick only moves a nonzero count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 5'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/aircon_cycle_controller.sv
// Compressor/fan sequencing with setpoint clamp, hysteresis, anti-short-cycle
// guards and a sleep timer that shuts the unit off.
module aircon_cycle_controller
  import aircon_pkg::*;
#(
  parameter int MIN_TEMP      = MIN_TEMP_DEFAULT,
  parameter int HYST          = HYST_DEFAULT,
  parameter int MIN_OFF_TICKS = MIN_OFF_TICKS_DEFAULT,
  parameter int MIN_ON_TICKS  = MIN_ON_TICKS_DEFAULT
) (
  input logic                      clk,
  input logic                      rst,
  aircon_cycle_controller_if.slave bus
);

  localparam logic [4:0] MIN_TEMP_V = 5'(MIN_TEMP);
  localparam logic [5:0] HYST_V     = 6'(HYST);
  localparam logic [4:0] MIN_OFF_V  = 5'(MIN_OFF_TICKS);
  localparam logic [4:0] MIN_ON_V   = 5'(MIN_ON_TICKS);

  state_e     state_q, state_d;
  logic       i_q, i_d;
  logic       compressor_q, compressor_d;
  logic [2:0] fan_q, fan_d;
  logic       expired_q, expired_d;

  logic [4:0] eff_set;
  logic [5:0] upper_thr;
  logic       room_hot, room_cool, pwr_edge;
  logic       guard_load, guard_done, guard_zero;
  logic [4:0] guard_value, guard_count;
  logic       timer_load_en, timer_zero, expire_evt;
  logic [4:0] timer_count;

  // The upper threshold is 6 bits wide so a setpoint of 31 never wraps.
  assign eff_set   = max5(bus.set_temp, MIN_TEMP_V);
  assign upper_thr = {1'b0, eff_set} + HYST_V;
  assign room_hot  = ({1'b0, bus.room_temp} > upper_thr);
  assign room_cool = (bus.room_temp <= eff_set);
  assign pwr_edge  = bus.i & ~i_q;
  assign i_d       = bus.i;

  assign guard_done    = guard_zero && (guard_count == '0);
  assign timer_load_en = bus.timer_load && (state_q != OFF);
  // A load in the same cycle suppresses the decrement, so it cannot expire either.
  assign expire_evt    = (state_q != OFF) && bus.tick && !bus.timer_load &&
                         !timer_zero && (timer_count[4:1] == 4'd0);

  tick_down_counter u_guard (
    .clk   (clk),
    .rst   (rst),
    .clear (state_d == OFF),
    .load  (guard_load),
    .value (guard_value),
    .tick  (bus.tick),
    .count (guard_count),
    .zero  (guard_zero)
  );

  tick_down_counter u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_d == OFF),
    .load  (timer_load_en),
    .value (bus.timer_set),
    .tick  (bus.tick),
    .count (timer_count),
    .zero  (timer_zero)
  );

  // State, input-edge and registered-output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OFF;
      i_q          <= 1'b0;
      compressor_q <= 1'b0;
      fan_q        <= '0;
      expired_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      compressor_q <= compressor_d;
      fan_q        <= fan_d;
      expired_q    <= expired_d;
    end
  end

  // Next state: power loss, then timer expiry, then the normal guard/thermostat moves.
  always_comb begin
    state_d     = state_q;
    guard_load  = 1'b0;
    guard_value = '0;
    if (!bus.i) begin
      state_d = OFF;
    end else if (expire_evt) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          if (pwr_edge) begin
            state_d     = LOCKOUT;
            guard_load  = 1'b1;
            guard_value = MIN_OFF_V;
          end
        end
        LOCKOUT: begin
          if (guard_done) begin
            state_d = IDLE;
          end
        end
        IDLE: begin
          if (room_hot) begin
            state_d     = COOL;
            guard_load  = 1'b1;
            guard_value = MIN_ON_V;
          end
        end
        COOL: begin
          if (guard_done && room_cool) begin
            state_d     = LOCKOUT;
            guard_load  = 1'b1;
            guard_value = MIN_OFF_V;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    compressor_d = (state_d == COOL);
    expired_d    = expire_evt;
    fan_d        = bus.fan_set;
    if (state_d == OFF) begin
      fan_d = '0;
    end else if ((state_d == COOL) && (bus.fan_set == 3'd0)) begin
      fan_d = 3'd1;
    end
  end

  assign bus.state      = state_q;
  assign bus.compressor = compressor_q;
  assign bus.fan        = fan_q;
  assign bus.expired    = expired_q;
  assign bus.timer_left = timer_count;

endmodule

// File: tb/tb_aircon_cycle_controller.sv
// Directed scoreboard bench for aircon_cycle_controller.
module tb_aircon_cycle_controller;
  import aircon_pkg::*;

  typedef struct {
    string      tag;
    logic [11:0] outs;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   fail_count;
  exp_t sb[$];

  aircon_cycle_controller_if bus ();

  aircon_cycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic checkOutput();
    exp_t       e;
    logic [11:0] observed;
    if (sb.size() == 0) begin
      fail_count++;
      $error("[TB] FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      observed = {bus.state, bus.compressor, bus.fan, bus.timer_left, bus.expired};
      tests_run++;
      assert (observed === e.outs) else begin
        fail_count++;
        $error("[TB] FAIL %s observed state=%0d comp=%0b fan=%0d left=%0d exp=%0b expected state=%0d comp=%0b fan=%0d left=%0d exp=%0b",
               e.tag, observed[11:10], observed[9], observed[8:6], observed[5:1], observed[0],
               e.outs[11:10], e.outs[9], e.outs[8:6], e.outs[5:1], e.outs[0]);
      end
    end
  endtask

  // Drive one cycle of strobes, record the outputs expected after the edge, then check.
  task automatic applyStimulus(input logic i_in, input logic tick_in, input logic load_in,
                               input string tag, input state_e e_state, input logic e_comp,
                               input logic [2:0] e_fan, input logic [4:0] e_left,
                               input logic e_exp);
    exp_t e;
    bus.i          = i_in;
    bus.tick       = tick_in;
    bus.timer_load = load_in;
    e.tag  = tag;
    e.outs = {logic'(e_state[1]), logic'(e_state[0]), e_comp, e_fan, e_left, e_exp};
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;

    // Reset with busy inputs
    rst           = 1'b1;
    bus.set_temp  = 5'd25;
    bus.room_temp = 5'd30;
    bus.fan_set   = 3'd5;
    bus.timer_set = 5'd9;
    applyStimulus(1, 1, 1, "reset",      OFF, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, "reset_hold", OFF, 0, 0, 0, 0);

    // Power-up with setpoint clamp to 17 (threshold 18)
    rst           = 1'b0;
    bus.set_temp  = 5'd10;
    bus.room_temp = 5'd20;
    bus.fan_set   = 3'd2;
    bus.timer_set = 5'd0;
    applyStimulus(1, 0, 0, "pwr_edge",     LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 0, 0, "lockout_wait", LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 1, 0, "lockout_t1",   LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 1, 0, "lockout_t2",   LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 1, 0, "lockout_t3",   LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 0, 0, "to_idle",      IDLE,    0, 2, 0, 0);
    applyStimulus(1, 0, 0, "to_cool",      COOL,    1, 2, 0, 0);

    // Minimum run time and fan floor of 1 while cooling
    bus.room_temp = 5'd17;
    bus.fan_set   = 3'd0;
    applyStimulus(1, 0, 0, "minrun_fan1",  COOL, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, "minrun_t1",    COOL, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, "minrun_t2",    COOL, 1, 1, 0, 0);
    bus.fan_set   = 3'd2;
    applyStimulus(1, 0, 0, "minrun_leave", LOCKOUT, 0, 2, 0, 0);

    // Hysteresis at setpoint 22: cool above 23, stop at 22 or below
    bus.set_temp  = 5'd22;
    bus.room_temp = 5'd23;
    applyStimulus(1, 1, 0, "hys_lk_t1",   LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 1, 0, "hys_lk_t2",   LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 1, 0, "hys_lk_t3",   LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 0, 0, "hys_idle",    IDLE,    0, 2, 0, 0);
    applyStimulus(1, 0, 0, "hys_23_idle", IDLE,    0, 2, 0, 0);
    bus.room_temp = 5'd24;
    applyStimulus(1, 0, 0, "hys_24_cool", COOL,    1, 2, 0, 0);
    bus.room_temp = 5'd23;
    applyStimulus(1, 1, 0, "hys_cool_t1", COOL,    1, 2, 0, 0);
    applyStimulus(1, 1, 0, "hys_cool_t2", COOL,    1, 2, 0, 0);
    applyStimulus(1, 0, 0, "hys_23_stay", COOL,    1, 2, 0, 0);
    bus.room_temp = 5'd22;
    applyStimulus(1, 0, 0, "hys_22_stop", LOCKOUT, 0, 2, 0, 0);

    // Sleep timer expiry overriding the run guard
    bus.room_temp = 5'd24;
    applyStimulus(1, 1, 0, "slp_lk_t1",   LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 1, 0, "slp_lk_t2",   LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 1, 0, "slp_lk_t3",   LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 0, 0, "slp_idle",    IDLE,    0, 2, 0, 0);
    applyStimulus(1, 0, 0, "slp_cool",    COOL,    1, 2, 0, 0);
    bus.timer_set = 5'd2;
    applyStimulus(1, 0, 1, "slp_load2",   COOL,    1, 2, 2, 0);
    applyStimulus(1, 1, 0, "slp_t1",      COOL,    1, 2, 1, 0);
    applyStimulus(1, 1, 0, "slp_expire",  OFF,     0, 0, 0, 1);
    applyStimulus(1, 0, 0, "slp_hold_i",  OFF,     0, 0, 0, 0);
    bus.timer_set = 5'd7;
    applyStimulus(1, 1, 1, "off_load_ign", OFF,    0, 0, 0, 0);
    applyStimulus(0, 0, 0, "i_fall",      OFF,     0, 0, 0, 0);

    // Restart with a tick on the guard-load cycle, then tick/load collision
    applyStimulus(1, 1, 0, "restart_tick", LOCKOUT, 0, 2, 0, 0);
    bus.timer_set = 5'd5;
    applyStimulus(1, 1, 1, "coll_load5",  LOCKOUT, 0, 2, 5, 0);
    applyStimulus(1, 1, 0, "coll_t2",     LOCKOUT, 0, 2, 4, 0);
    applyStimulus(1, 1, 0, "coll_t3",     LOCKOUT, 0, 2, 3, 0);
    applyStimulus(1, 0, 0, "coll_idle",   IDLE,    0, 2, 3, 0);
    applyStimulus(1, 0, 0, "coll_cool",   COOL,    1, 2, 3, 0);
    applyStimulus(0, 1, 0, "drop_i_tick", OFF,     0, 0, 0, 0);

    // Reset while cooling, then power edge right after reset
    applyStimulus(1, 0, 0, "rc_edge",     LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 1, 0, "rc_t1",       LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 1, 0, "rc_t2",       LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 1, 0, "rc_t3",       LOCKOUT, 0, 2, 0, 0);
    applyStimulus(1, 0, 0, "rc_idle",     IDLE,    0, 2, 0, 0);
    applyStimulus(1, 0, 0, "rc_cool",     COOL,    1, 2, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 0, 0, "rst_in_cool", OFF,     0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(1, 0, 0, "post_rst_edge", LOCKOUT, 0, 2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/aircon_cycle_controller.md
# aircon_cycle_controller

Sequencing controller for the air-conditioner datapath: decides each cycle whether the compressor runs, what fan speed is driven, and when the sleep timer shuts the unit off. It consumes the stored setpoint, fan and timer values plus a room-temperature sample and a slow `tick` strobe. It enforces setpoint clamping, thermostat hysteresis and compressor anti-short-cycle guards. It sits between the user-setting memories and the compressor/fan drivers.

## Interface
Parameters:
- `MIN_TEMP`, 17: lowest legal setpoint; lower requests are clamped up to it.
- `HYST`, 1: hysteresis above the setpoint, in degrees.
- `MIN_OFF_TICKS`, 3: minimum compressor rest time, in ticks.
- `MIN_ON_TICKS`, 2: minimum compressor run time, in ticks.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `i` in 1: power request; the unit starts only on its rising edge.
- `tick` in 1: one-cycle timebase strobe, one per minute.
- `set_temp` in 5: requested temperature, unsigned.
- `room_temp` in 5: measured temperature, unsigned.
- `fan_set` in 3: requested fan speed, 0–7.
- `timer_set` in 5: sleep timer value in ticks; 0 means disabled.
- `timer_load` in 1: one-cycle strobe that loads `timer_set`.
- `compressor` out 1: compressor enable.
- `fan` out 3: fan speed drive.
- `timer_left` out 5: remaining sleep ticks.
- `state` out 2: current FSM state.
- `expired` out 1: one-cycle pulse when the sleep timer reaches 0.

## Operation
- `eff_set = max(set_temp, MIN_TEMP)`; this is a 5-bit unsigned compare.
- The upper threshold `eff_set + HYST` is computed in 6 bits, so there is no wrap at 31.
- `i_q` is registered `i`. A power-on edge is `i & ~i_q`.
- States:
  - `OFF`: compressor=0, fan=0, timer_left=0, guard=0. On a power-on edge, go to `LOCKOUT` and load guard=`MIN_OFF_TICKS`.
  - `LOCKOUT`: compressor=0, fan=`fan_set`. Guard decrements on `tick`. When guard==0, go to `IDLE`.
  - `IDLE`: compressor=0, fan=`fan_set`. When `room_temp > eff_set+HYST`, go to `COOL` and load guard=`MIN_ON_TICKS`.
  - `COOL`: compressor=1, fan=`max(fan_set,1)`. Guard decrements on `tick`. When guard==0 and `room_temp <= eff_set`, go to `LOCKOUT` and load guard=`MIN_OFF_TICKS`.
- Sleep timer:
  - `timer_load` loads `timer_set` in any state except `OFF`, where the load is ignored.
  - On `tick`, a nonzero timer decrements.
  - A decrement from 1 to 0 raises `expired` and forces `OFF`.
- Priority, highest first:
  1. `rst`
  2. `i==0` forces `OFF`
  3. timer expiry forces `OFF`; this overrides the `MIN_ON_TICKS` guard
  4. normal FSM transitions
- `timer_load` and `tick` in the same cycle: load wins, with no decrement that cycle.
- After expiry, the unit stays in `OFF` while `i` is held at 1. Restart requires `i` to fall and rise again.
- A tick arriving in the same cycle as a guard load is not counted against the new guard.

## Timing
- All outputs are registered and change one cycle after the sampled condition.
- Reset values: compressor=0, fan=0, timer_left=0, state=`OFF`, expired=0, `i_q`=0, guard=0.
- If `i` is high in the first cycle after reset, a power-on edge is detected and `LOCKOUT` is entered the next cycle.
- `fan_set` and `set_temp` changes take effect one cycle later, without restarting the guards.
- If `i` drops mid-`COOL`, compressor=0 in the next cycle. The `MIN_ON_TICKS` guard is overridden in this case.
- `expired` is high for exactly one cycle, coincident with the first cycle of `OFF`.

## Structure
- Package `aircon_pkg`:
  - state encoding: `OFF`=0, `LOCKOUT`=1, `IDLE`=2, `COOL`=3
  - default constants for `MIN_TEMP` and `HYST`
- Sub-module `tick_down_counter`: loadable 5-bit down-counter.
  - Ports: load, value, tick, clear.
  - Outputs: count and zero flag.
  - Instantiated twice: once for the guard counter and once for the sleep timer.
- FSM, clamp and threshold logic live in the top module.

## Test plan
- Reset: assert `rst` with arbitrary inputs -> all outputs 0, state=`OFF`. Also `rst` mid-`COOL` -> compressor=0 in the next cycle.
- Power-up with clamp: set_temp=10, room=20, fan_set=2, raise `i`, then 3 ticks -> state goes `LOCKOUT` → `IDLE` → `COOL` (20 > 18), compressor=1, fan=2.
- Minimum run: in `COOL`, room drops to 17 before the first tick -> remains `COOL` until the 2nd tick, then `LOCKOUT` with compressor=0. fan_set=0 during `COOL` -> fan=1.
- Hysteresis: set_temp=22, room=23 -> remains `IDLE`. room=24 -> `COOL`. room=22 -> leaves `COOL` after the guard; room=23 does not.
- Sleep timer: timer_load=2 in `COOL`, then 2 ticks -> `expired` pulse, state=`OFF`, all outputs 0. With `i` held at 1 -> stays `OFF`. Toggle `i` -> `LOCKOUT`.
- Collisions: `tick` and `timer_load`(5) in the same cycle -> timer_left=5. Drop `i` in the same cycle as a `tick` in `COOL` -> state=`OFF`, compressor=0.
